// File: rtl/axo_mem_arbiter.sv
// Arbitrates the core's data and fetch ports onto one registered memory bus.
// Halfword-aligned fetches are split into two word reads and reassembled.
module axo_mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [1:0]  d_asize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  input  logic        p_re,
  input  logic [31:1] p_addr,
  output logic [31:0] p_data,
  output logic        p_ready,
  output logic        m_re,
  output logic        m_we,
  output logic [1:0]  m_asize,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  typedef enum logic [2:0] {IDLE, DATA, FETCH_LO, FETCH_HI, RESP} state_e;

  state_e      state_q, state_d;
  logic        split_q, split_d;
  logic        last_q, last_d;  // 1: fetch port received the previous grant
  logic        m_re_q, m_re_d, m_we_q, m_we_d;
  logic [1:0]  m_asize_q, m_asize_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [31:0] d_rdata_q, d_rdata_d, p_data_q, p_data_d;
  logic        d_ready_q, d_ready_d, p_ready_q, p_ready_d;
  logic        gnt_d, gnt_p;

  assign gnt_d = (d_re | d_we) & (~p_re | ~FAIR | last_q);
  assign gnt_p = p_re & ~gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      split_q   <= 1'b0;
      last_q    <= 1'b1;
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_asize_q <= 2'd0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      p_data_q  <= 32'd0;
      d_ready_q <= 1'b0;
      p_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      split_q   <= split_d;
      last_q    <= last_d;
      m_re_q    <= m_re_d;
      m_we_q    <= m_we_d;
      m_asize_q <= m_asize_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      d_rdata_q <= d_rdata_d;
      p_data_q  <= p_data_d;
      d_ready_q <= d_ready_d;
      p_ready_q <= p_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_d) state_d = DATA;
                else if (gnt_p) state_d = FETCH_LO;
      DATA:     if (m_ready) state_d = RESP;
      FETCH_LO: if (m_ready) state_d = split_q ? FETCH_HI : RESP;
      FETCH_HI: if (m_ready) state_d = RESP;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    split_d   = split_q;
    last_d    = last_q;
    m_re_d    = m_re_q;
    m_we_d    = m_we_q;
    m_asize_d = m_asize_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    d_rdata_d = d_rdata_q;
    p_data_d  = p_data_q;
    d_ready_d = d_ready_q;
    p_ready_d = p_ready_q;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          m_addr_d  = d_addr;
          m_asize_d = d_asize;
          m_wdata_d = d_wdata;
          m_we_d    = d_we;
          m_re_d    = ~d_we;
          last_d    = 1'b0;
        end else if (gnt_p) begin
          m_addr_d  = {p_addr[31:2], 2'b00};
          m_asize_d = 2'd2;
          m_re_d    = 1'b1;
          m_we_d    = 1'b0;
          split_d   = p_addr[1];
          last_d    = 1'b1;
        end
      end
      DATA: if (m_ready) begin
        if (!m_we_q) d_rdata_d = m_rdata;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        d_ready_d = 1'b1;
      end
      FETCH_LO: if (m_ready) begin
        if (split_q) begin
          // upper half of the first word is the low half of the instruction
          p_data_d[15:0] = m_rdata[31:16];
          m_addr_d       = m_addr_q + 32'd4;
        end else begin
          p_data_d  = m_rdata;
          p_ready_d = 1'b1;
          m_re_d    = 1'b0;
        end
      end
      FETCH_HI: if (m_ready) begin
        p_data_d[31:16] = m_rdata[15:0];
        p_ready_d       = 1'b1;
        m_re_d          = 1'b0;
      end
      default: begin
        d_ready_d = 1'b0;
        p_ready_d = 1'b0;
      end
    endcase
  end

  assign m_re    = m_re_q;
  assign m_we    = m_we_q;
  assign m_asize = m_asize_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign p_data  = p_data_q;
  assign p_ready = p_ready_q;

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Directed bench for axo_mem_arbiter: one fair and one data-priority instance
// share stimulus and a small combinational word memory.
module tb_axo_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_re = 1'b0, d_we = 1'b0;
  logic [1:0]  d_asize = 2'd0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        p_re = 1'b0;
  logic [31:0] p_byte = 32'd0;
  logic [31:1] p_addr;
  logic        mrdy = 1'b1;

  logic [31:0] f_d_rdata, f_p_data, f_m_addr, f_m_wdata, f_m_rdata;
  logic        f_d_ready, f_p_ready, f_m_re, f_m_we;
  logic [1:0]  f_m_asize;
  logic [31:0] q_d_rdata, q_p_data, q_m_addr, q_m_wdata, q_m_rdata;
  logic        q_d_ready, q_p_ready, q_m_re, q_m_we;
  logic [1:0]  q_m_asize;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign p_addr = p_byte[31:1];

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0010: memf = 32'h00A0_0093;
      32'hFFFF_FFFC: memf = 32'hBEEF_1234;
      32'h0000_0000: memf = 32'h5678_CAFE;
      32'h0000_0020: memf = 32'h1122_3344;
      default:       memf = ~a;
    endcase
  endfunction

  assign f_m_rdata = memf(f_m_addr);
  assign q_m_rdata = memf(q_m_addr);

  axo_mem_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .rst(rst), .d_re(d_re), .d_we(d_we), .d_asize(d_asize),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(f_d_rdata), .d_ready(f_d_ready),
    .p_re(p_re), .p_addr(p_addr), .p_data(f_p_data), .p_ready(f_p_ready),
    .m_re(f_m_re), .m_we(f_m_we), .m_asize(f_m_asize), .m_addr(f_m_addr),
    .m_wdata(f_m_wdata), .m_rdata(f_m_rdata), .m_ready(mrdy)
  );

  axo_mem_arbiter #(.FAIR(1'b0)) u_prio (
    .clk(clk), .rst(rst), .d_re(d_re), .d_we(d_we), .d_asize(d_asize),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(q_d_rdata), .d_ready(q_d_ready),
    .p_re(p_re), .p_addr(p_addr), .p_data(q_p_data), .p_ready(q_p_ready),
    .m_re(q_m_re), .m_we(q_m_we), .m_asize(q_m_asize), .m_addr(q_m_addr),
    .m_wdata(q_m_wdata), .m_rdata(q_m_rdata), .m_ready(mrdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_ctrl", {26'd0, f_m_re, f_m_we, f_m_asize, f_d_ready, f_p_ready}, 32'd0);
    chk("rst_addr", f_m_addr, 32'd0);
    chk("rst_pdata", f_p_data, 32'd0);
    chk("rst_drdata", f_d_rdata, 32'd0);
    chk("rst_prio_ctrl", {30'd0, q_m_re, q_m_we}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_req", {30'd0, f_m_re, f_m_we}, 32'd0);

    // contention: fair alternates starting with data, priority always data
    d_re = 1'b1; d_asize = 2'd2; d_addr = 32'h20;
    p_re = 1'b1; p_byte = 32'h40;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("fair_grant%0d", g), f_m_addr, (g % 2 == 0) ? 32'h20 : 32'h40);
      chk($sformatf("prio_grant%0d", g), q_m_addr, 32'h20);
      tick();
      chk($sformatf("fair_rdy%0d", g), {30'd0, f_d_ready, f_p_ready},
          (g % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    d_re = 1'b0; p_re = 1'b0;
    chk("cont_drdata", f_d_rdata, 32'h1122_3344);
    chk("cont_pdata", f_p_data, ~32'h40);

    // aligned fetch, zero-wait
    p_re = 1'b1; p_byte = 32'h10;
    tick();
    chk("al_maddr", f_m_addr, 32'h10);
    chk("al_mre_asize", {29'd0, f_m_re, f_m_asize}, 32'h6);
    chk("al_prdy_early", {31'd0, f_p_ready}, 32'd0);
    tick();
    p_re = 1'b0;
    chk("al_prdy", {31'd0, f_p_ready}, 32'd1);
    chk("al_pdata", f_p_data, 32'h00A0_0093);
    chk("al_mre_drop", {31'd0, f_m_re}, 32'd0);
    tick();
    chk("al_prdy_clr", {31'd0, f_p_ready}, 32'd0);
    tick();

    // split fetch with address wrap
    p_re = 1'b1; p_byte = 32'hFFFF_FFFE;
    tick();
    chk("sp_maddr_lo", f_m_addr, 32'hFFFF_FFFC);
    tick();
    chk("sp_maddr_hi", f_m_addr, 32'h0000_0000);
    chk("sp_mre_hi", {30'd0, f_m_re, f_p_ready}, 32'd2);
    tick();
    p_re = 1'b0;
    chk("sp_pdata", f_p_data, 32'hCAFE_BEEF);
    chk("sp_prdy", {30'd0, f_m_re, f_p_ready}, 32'd1);
    tick();
    chk("sp_prdy_clr", {31'd0, f_p_ready}, 32'd0);

    // data read
    d_re = 1'b1; d_asize = 2'd2; d_addr = 32'h10;
    tick();
    chk("rd_ctrl", {29'd0, f_m_re, f_m_we, f_d_ready}, 32'h4);
    tick();
    d_re = 1'b0;
    chk("rd_drdata", f_d_rdata, 32'h00A0_0093);
    chk("rd_drdy", {31'd0, f_d_ready}, 32'd1);
    tick();
    tick();

    // data write: write wins over read, d_rdata untouched
    d_re = 1'b1; d_we = 1'b1; d_asize = 2'd0; d_addr = 32'h103; d_wdata = 32'hAB;
    tick();
    chk("wr_ctrl", {28'd0, f_m_we, f_m_re, f_m_asize}, 32'h8);
    chk("wr_maddr", f_m_addr, 32'h103);
    chk("wr_mwdata", f_m_wdata, 32'hAB);
    tick();
    d_re = 1'b0; d_we = 1'b0;
    chk("wr_drdy", {31'd0, f_d_ready}, 32'd1);
    chk("wr_drdata", f_d_rdata, 32'h00A0_0093);
    tick();
    chk("wr_drdy_clr", {29'd0, f_d_ready, f_m_we, f_m_re}, 32'd0);
    tick();

    // split fetch with 5 wait states in FETCH_HI
    p_re = 1'b1; p_byte = 32'h22;
    tick();
    chk("ws_maddr_lo", f_m_addr, 32'h20);
    tick();
    mrdy = 1'b0;
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("ws_hold%0d", w), {f_m_addr[29:0], f_m_re, f_p_ready}, {30'h24 >> 0, 2'b10});
      tick();
    end
    mrdy = 1'b1;
    tick();
    p_re = 1'b0;
    chk("ws_prdy", {31'd0, f_p_ready}, 32'd1);
    chk("ws_pdata", f_p_data, 32'hFFDB_1122);
    tick();
    chk("ws_prdy_once", {31'd0, f_p_ready}, 32'd0);
    tick();

    // reset while in FETCH_HI, then contention must favour data
    p_re = 1'b1; p_byte = 32'h22;
    tick(); tick();
    chk("rstm_in_hi", f_m_addr, 32'h24);
    mrdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; p_re = 1'b0; mrdy = 1'b1;
    chk("rstm_ctrl", {26'd0, f_m_re, f_m_we, f_m_asize, f_d_ready, f_p_ready}, 32'd0);
    chk("rstm_maddr", f_m_addr, 32'd0);
    chk("rstm_mwdata", f_m_wdata, 32'd0);
    chk("rstm_drdata", f_d_rdata, 32'd0);
    chk("rstm_pdata", f_p_data, 32'd0);
    d_re = 1'b1; d_asize = 2'd2; d_addr = 32'h30;
    p_re = 1'b1; p_byte = 32'h40;
    tick();
    chk("rstm_first_grant", f_m_addr, 32'h30);
    tick();
    d_re = 1'b0; p_re = 1'b0;
    chk("rstm_drdy", {30'd0, f_d_ready, f_p_ready}, 32'd2);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
